// File: rtl/fc_array_ctrl_pkg.sv
// Shared types and helpers for the fully-connected PE-chain sequencer.
// Imported by the controller top and its result-tag delay line.
package fc_array_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } fc_state_e;

    localparam int DEF_ROWS = 8;

    // Weight-read-to-accumulator latency: one buffer read cycle plus one stage per PE.
    function automatic int unsigned lat_of(input int unsigned rows);
        return rows + 1;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/fc_valid_pipe.sv
// Fixed-depth delay line carrying {valid, addr, first} from the weight read
// to the moment the matching psum leaves the last PE.
module fc_valid_pipe
    import fc_array_ctrl_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic          in_first,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          out_first
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] first_q;
    logic [AW-1:0]    addr_q [DEPTH];

    // NOTE: this is a short flop chain, not a RAM, so every stage (data too) is
    // reset; that keeps the accumulator-side outputs at zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            first_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            first_q[0] <= in_first;
            addr_q[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                first_q[i] <= first_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_first = first_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/fc_array_ctrl.sv
// Tile sequencer for the 1-D fully-connected PE chain: loads ROWS ifmap values,
// streams out_len weight vectors, and tags psums leaving the last PE for the accumulator.
module fc_array_ctrl
    import fc_array_ctrl_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int LEN_W = 10,
    parameter int W_AW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] in_len,
    input  logic [LEN_W-1:0] out_len,
    output logic             busy,
    output logic             done,
    output logic             ifmap_rd_en,
    output logic [LEN_W-1:0] ifmap_rd_addr,
    output logic             ifmap_zero,
    output logic             pe_load,
    output logic             w_rd_en,
    output logic [W_AW-1:0]  w_rd_addr,
    output logic             acc_wr_en,
    output logic [LEN_W-1:0] acc_addr,
    output logic             acc_first
);

    localparam int LAT   = lat_of(ROWS);
    localparam int IDX_W = LEN_W + 1;

    fc_state_e        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] in_len_q, out_len_q, ntiles_q, tile_q;
    logic [IDX_W-1:0] ifmap_base_q;
    logic [W_AW-1:0]  w_base_q;
    logic             pe_load_q, ifmap_zero_q;

    logic             accept, tile_adv, last_tile;
    logic [IDX_W-1:0] idx;
    logic             idx_in_range;
    logic             streaming;

    // Within a tile the farthest PE is loaded first, so the index counts down.
    assign idx          = ifmap_base_q + IDX_W'(ROWS - 1) - IDX_W'(cnt_q);
    assign idx_in_range = idx < IDX_W'(in_len_q);
    assign last_tile    = (IDX_W'(tile_q) + IDX_W'(1)) >= IDX_W'(ntiles_q);
    assign streaming    = (state_q == STREAM);

    // NOTE: every signal driven here gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + LEN_W'(1);
        accept   = 1'b0;
        tile_adv = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = (in_len == '0 || out_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == LEN_W'(ROWS - 1)) state_d = STREAM;
            end
            STREAM: begin
                if (cnt_q == out_len_q - LEN_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                // Hold the loaded ifmap until the last psum of this tile has left the chain.
                if (cnt_q == LEN_W'(LAT - 1)) begin
                    if (last_tile) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        tile_adv = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_len_q     <= '0;
            out_len_q    <= '0;
            ntiles_q     <= '0;
            tile_q       <= '0;
            ifmap_base_q <= '0;
            w_base_q     <= '0;
            pe_load_q    <= 1'b0;
            ifmap_zero_q <= 1'b0;
        end else begin
            // PE load and pad flags line up with the data returning from the 1-cycle ifmap read.
            pe_load_q    <= (state_q == LOAD);
            ifmap_zero_q <= (state_q == LOAD) && !idx_in_range;
            if (accept) begin
                in_len_q     <= in_len;
                out_len_q    <= out_len;
                ntiles_q     <= LEN_W'(ceil_div(32'(in_len), ROWS));
                tile_q       <= '0;
                ifmap_base_q <= '0;
                w_base_q     <= '0;
            end else if (tile_adv) begin
                tile_q       <= tile_q + LEN_W'(1);
                ifmap_base_q <= ifmap_base_q + IDX_W'(ROWS);
                w_base_q     <= w_base_q + W_AW'(out_len_q);
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign ifmap_rd_en   = (state_q == LOAD) && idx_in_range;
    assign ifmap_rd_addr = (state_q == LOAD) ? idx[LEN_W-1:0] : '0;
    assign ifmap_zero    = ifmap_zero_q;
    assign pe_load       = pe_load_q;
    assign w_rd_en       = streaming;
    assign w_rd_addr     = streaming ? (w_base_q + W_AW'(cnt_q)) : '0;

    fc_valid_pipe #(
        .DEPTH (LAT),
        .AW    (LEN_W)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (streaming),
        .in_addr   (streaming ? cnt_q : '0),
        .in_first  (streaming && (tile_q == '0)),
        .out_valid (acc_wr_en),
        .out_addr  (acc_addr),
        .out_first (acc_first)
    );

endmodule

// File: tb/tb_fc_array_ctrl.sv
// Directed bench for fc_array_ctrl: cycle-exact strobe sequences against
// hand-computed expectations for ROWS=8.
module tb_fc_array_ctrl;

    localparam int ROWS  = 8;
    localparam int LEN_W = 10;
    localparam int W_AW  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] in_len = '0;
    logic [LEN_W-1:0] out_len = '0;
    logic             busy, done, ifmap_rd_en, ifmap_zero, pe_load, w_rd_en, acc_wr_en, acc_first;
    logic [LEN_W-1:0] ifmap_rd_addr, acc_addr;
    logic [W_AW-1:0]  w_rd_addr;

    fc_array_ctrl #(.ROWS(ROWS), .LEN_W(LEN_W), .W_AW(W_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_len        (in_len),
        .out_len       (out_len),
        .busy          (busy),
        .done          (done),
        .ifmap_rd_en   (ifmap_rd_en),
        .ifmap_rd_addr (ifmap_rd_addr),
        .ifmap_zero    (ifmap_zero),
        .pe_load       (pe_load),
        .w_rd_en       (w_rd_en),
        .w_rd_addr     (w_rd_addr),
        .acc_wr_en     (acc_wr_en),
        .acc_addr      (acc_addr),
        .acc_first     (acc_first)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int rd_addr_q[$], rd_cyc_q[$], zero_cyc_q[$], pe_cyc_q[$];
    int w_addr_q[$], w_cyc_q[$], acc_addr_q[$], acc_first_q[$], acc_cyc_q[$];
    int busy_n, done_n, done_cyc, post_rst_nz, busy_after_done;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, ".len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    function automatic int outputs_nonzero();
        return int'(busy | done | ifmap_rd_en | (|ifmap_rd_addr) | ifmap_zero | pe_load |
                    w_rd_en | (|w_rd_addr) | acc_wr_en | (|acc_addr) | acc_first);
    endfunction

    // Cycle 0 is the cycle in which start is sampled; cycle c is observed at the
    // falling edge after the c-th rising edge.
    task automatic run(input int il, input int ol, input int rst_cyc, input bit hammer, input int max_cyc);
        bit finish_next = 1'b0;
        rd_addr_q = {}; rd_cyc_q = {}; zero_cyc_q = {}; pe_cyc_q = {};
        w_addr_q = {}; w_cyc_q = {}; acc_addr_q = {}; acc_first_q = {}; acc_cyc_q = {};
        busy_n = 0; done_n = 0; done_cyc = -1; post_rst_nz = -1; busy_after_done = -1;
        @(negedge clk);
        in_len  = LEN_W'(il);
        out_len = LEN_W'(ol);
        start   = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (finish_next) begin
                busy_after_done = int'(busy);
                start = 1'b0;
                break;
            end
            if (ifmap_rd_en) begin rd_addr_q.push_back(int'(ifmap_rd_addr)); rd_cyc_q.push_back(c); end
            if (pe_load) pe_cyc_q.push_back(c);
            if (ifmap_zero) zero_cyc_q.push_back(c);
            if (w_rd_en) begin w_addr_q.push_back(int'(w_rd_addr)); w_cyc_q.push_back(c); end
            if (acc_wr_en) begin
                acc_addr_q.push_back(int'(acc_addr));
                acc_first_q.push_back(int'(acc_first));
                acc_cyc_q.push_back(c);
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rst_cyc > 0 && c == rst_cyc + 1) post_rst_nz = outputs_nonzero();
            rst = (rst_cyc > 0 && c == rst_cyc);
            if (hammer) begin
                start   = 1'b1;
                in_len  = LEN_W'($urandom_range(1, 40));
                out_len = LEN_W'($urandom_range(1, 40));
            end else begin
                start = 1'b0;
            end
            if (done && rst_cyc == 0) finish_next = 1'b1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int e[$];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outputs_nonzero(), 0);
        rst = 1'b0;

        // Two full tiles, no padding.
        run(16, 4, 0, 1'b0, 80);
        e = '{7, 6, 5, 4, 3, 2, 1, 0, 15, 14, 13, 12, 11, 10, 9, 8};
        check_seq("t1.rd_addr", rd_addr_q, e);
        e = '{1, 2, 3, 4, 5, 6, 7, 8, 22, 23, 24, 25, 26, 27, 28, 29};
        check_seq("t1.rd_cyc", rd_cyc_q, e);
        e = '{2, 3, 4, 5, 6, 7, 8, 9, 23, 24, 25, 26, 27, 28, 29, 30};
        check_seq("t1.pe_cyc", pe_cyc_q, e);
        check("t1.zero_n", zero_cyc_q.size(), 0);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_seq("t1.w_addr", w_addr_q, e);
        e = '{9, 10, 11, 12, 30, 31, 32, 33};
        check_seq("t1.w_cyc", w_cyc_q, e);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_seq("t1.acc_addr", acc_addr_q, e);
        e = '{1, 1, 1, 1, 0, 0, 0, 0};
        check_seq("t1.acc_first", acc_first_q, e);
        e = '{18, 19, 20, 21, 39, 40, 41, 42};
        check_seq("t1.acc_cyc", acc_cyc_q, e);
        check("t1.done_cyc", done_cyc, 43);
        check("t1.done_n", done_n, 1);
        check("t1.busy_n", busy_n, 43);
        check("t1.busy_after_done", busy_after_done, 0);

        // Single padded tile.
        run(5, 3, 0, 1'b0, 60);
        e = '{4, 3, 2, 1, 0};
        check_seq("t2.rd_addr", rd_addr_q, e);
        e = '{4, 5, 6, 7, 8};
        check_seq("t2.rd_cyc", rd_cyc_q, e);
        e = '{2, 3, 4};
        check_seq("t2.zero_cyc", zero_cyc_q, e);
        check("t2.pe_n", pe_cyc_q.size(), 8);
        e = '{0, 1, 2};
        check_seq("t2.w_addr", w_addr_q, e);
        e = '{18, 19, 20};
        check_seq("t2.acc_cyc", acc_cyc_q, e);
        e = '{1, 1, 1};
        check_seq("t2.acc_first", acc_first_q, e);
        check("t2.done_cyc", done_cyc, 21);

        // Zero-length layers go straight to DONE.
        run(0, 5, 0, 1'b0, 20);
        check("t3a.done_cyc", done_cyc, 1);
        check("t3a.busy_n", busy_n, 1);
        check("t3a.strobes", rd_cyc_q.size() + w_cyc_q.size() + acc_cyc_q.size() + pe_cyc_q.size(), 0);
        run(8, 0, 0, 1'b0, 20);
        check("t3b.done_cyc", done_cyc, 1);
        check("t3b.busy_n", busy_n, 1);
        check("t3b.strobes", rd_cyc_q.size() + w_cyc_q.size() + acc_cyc_q.size() + pe_cyc_q.size(), 0);

        // Reset during STREAM of tile 1 abandons the layer.
        run(16, 4, 31, 1'b0, 100);
        check("t4.post_rst_outputs", post_rst_nz, 0);
        check("t4.done_n", done_n, 0);
        e = '{18, 19, 20, 21};
        check_seq("t4.acc_cyc", acc_cyc_q, e);
        e = '{9, 10, 11, 12, 30, 31};
        check_seq("t4.w_cyc", w_cyc_q, e);
        run(5, 3, 0, 1'b0, 60);
        check("t4.fresh_done_cyc", done_cyc, 21);
        e = '{0, 1, 2};
        check_seq("t4.fresh_acc_addr", acc_addr_q, e);

        // Start held high and lengths scrambled while busy, including the DONE cycle.
        run(16, 4, 0, 1'b1, 80);
        check("t5.done_cyc", done_cyc, 43);
        check("t5.done_n", done_n, 1);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_seq("t5.w_addr", w_addr_q, e);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_seq("t5.acc_addr", acc_addr_q, e);
        check("t5.busy_after_done", busy_after_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
